// File: rtl/siso_frame_arbiter.sv
// rtl/siso_frame_arbiter.sv - round-robin arbiter sharing one MSB-first serial channel between two requesters
module siso_frame_arbiter #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sout,
  output logic             sout_en,
  output logic             busy,
  output logic             grant_id,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t         state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]  cnt;
  logic [3:0]     gcnt;
  logic           ptr;     // 1: req1 wins a tie, 0: req0 wins a tie
  logic           grant0;
  logic           grant1;

  assign grant0 = req0_valid & (~req1_valid | ~ptr);
  assign grant1 = req1_valid & (~req0_valid | ptr);

  // Reset masks the handshake so a word is never consumed in a reset cycle.
  assign req0_ready = (state == S_IDLE) & ~rst & grant0;
  assign req1_ready = (state == S_IDLE) & ~rst & grant1;

  assign sout_en = (state == S_SHIFT);
  assign sout    = sout_en & sreg[WIDTH-1];
  assign busy    = (state != S_IDLE);
  assign done    = sout_en & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sreg     <= '0;
      cnt      <= '0;
      gcnt     <= '0;
      ptr      <= 1'b0;
      grant_id <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0_ready | req1_ready) begin
            sreg     <= req1_ready ? req1_data : req0_data;
            grant_id <= req1_ready;
            ptr      <= req0_ready;
            cnt      <= '0;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          if (cnt == LAST) begin
            cnt   <= '0;
            gcnt  <= '0;
            state <= (GAP == 0) ? S_IDLE : S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt == GAP_LAST) begin
            gcnt  <= '0;
            state <= S_IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_siso_frame_arbiter.sv
// tb/tb_siso_frame_arbiter.sv - directed bench for siso_frame_arbiter (GAP=1 and GAP=0 builds)
module tb_siso_frame_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready, sout, sout_en, busy, grant_id, done;

  logic       g0_valid = 1'b0, g1_valid = 1'b0;
  logic [7:0] g0_data = 8'h00, g1_data = 8'h00;
  logic       g_ready0, g_ready1, g_sout, g_sout_en, g_busy, g_grant_id, g_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_prev = 0;
  bit found;
  logic [7:0] w;

  always #5 clk = ~clk;

  siso_frame_arbiter #(.WIDTH(8), .GAP(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .sout(sout), .sout_en(sout_en), .busy(busy), .grant_id(grant_id), .done(done)
  );

  siso_frame_arbiter #(.WIDTH(8), .GAP(0)) u_dut_g0 (
    .clk(clk), .rst(rst),
    .req0_valid(g0_valid), .req0_data(g0_data), .req0_ready(g_ready0),
    .req1_valid(g1_valid), .req1_data(g1_data), .req1_ready(g_ready1),
    .sout(g_sout), .sout_en(g_sout_en), .busy(g_busy), .grant_id(g_grant_id), .done(g_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // reset, then a single req0 frame with data changed mid-shift
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    check("rst_sout", sout, 0);
    check("rst_sout_en", sout_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);

    req0_valid = 1'b1;
    req0_data  = 8'hB4;
    settle();
    check("t1_ready0", req0_ready, 1);
    check("t1_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    w = 8'hB4;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) req0_data = 8'h00;
      settle();
      check($sformatf("t1_sout_bit%0d", k), sout, w[7-k]);
      check($sformatf("t1_sout_en_bit%0d", k), sout_en, 1);
      check($sformatf("t1_done_bit%0d", k), done, (k == 7));
      check($sformatf("t1_grant_bit%0d", k), grant_id, 0);
      tick();
    end
    check("t1_gap_sout_en", sout_en, 0);
    check("t1_gap_sout", sout, 0);
    check("t1_gap_busy", busy, 1);
    check("t1_gap_done", done, 0);
    tick();
    check("t1_idle_busy", busy, 0);

    // contention: both valid, grants alternate from reset, starts 10 cycles apart
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 8'hFF;
    req1_valid = 1'b1; req1_data = 8'h00;
    for (int f = 0; f < 4; f++) begin
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
        settle();
        if (req0_ready | req1_ready) found = 1'b1;
        else tick();
      end
      check($sformatf("t2_found_f%0d", f), found, 1);
      check($sformatf("t2_ready0_f%0d", f), req0_ready, (f % 2 == 0));
      check($sformatf("t2_ready1_f%0d", f), req1_ready, (f % 2 == 1));
      if (f > 0) check($sformatf("t2_spacing_f%0d", f), cyc - hs_prev, 10);
      hs_prev = cyc;
      tick();
      check($sformatf("t2_grant_f%0d", f), grant_id, (f % 2 == 1));
      check($sformatf("t2_sout_f%0d", f), sout, (f % 2 == 0));
      check($sformatf("t2_sout_en_f%0d", f), sout_en, 1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      settle();
      if (!busy) found = 1'b0 | 1'b1;
      else tick();
    end
    check("t2_drain", found, 1);

    // held request: req1 waits through a req0 frame, then shifts 8'h5A
    req0_valid = 1'b1;
    req0_data  = 8'h3C;
    settle();
    check("t3_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_data  = 8'h5A;
    for (int i = 0; i < 9; i++) begin
      settle();
      check($sformatf("t3_hold_ready1_c%0d", i), req1_ready, 0);
      tick();
    end
    settle();
    check("t3_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    w = 8'h5A;
    for (int k = 0; k < 8; k++) begin
      settle();
      check($sformatf("t3_sout_bit%0d", k), sout, w[7-k]);
      check($sformatf("t3_grant_bit%0d", k), grant_id, 1);
      tick();
    end
    tick();
    check("t3_idle_busy", busy, 0);

    // reset mid-frame after 3 bits of 8'hC3
    req0_valid = 1'b1;
    req0_data  = 8'hC3;
    settle();
    check("t4_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    w = 8'hC3;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("t4_sout_bit%0d", k), sout, w[7-k]);
      check($sformatf("t4_done_bit%0d", k), done, 0);
      tick();
    end
    rst = 1'b1;
    settle();
    check("t4_done_at_rst", done, 0);
    tick();
    rst = 1'b0;
    settle();
    check("t4_sout_en", sout_en, 0);
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_grant_id", grant_id, 0);
    rst = 1'b1;
    req1_valid = 1'b1;
    req1_data  = 8'h01;
    settle();
    check("t4_rst_blocks_ready1", req1_ready, 0);
    tick();
    rst = 1'b0;
    settle();
    check("t4_ready1_after_rst", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    settle();
    check("t4_grant_id1", grant_id, 1);
    check("t4_busy1", busy, 1);
    for (int i = 0; i < 9; i++) tick();
    check("t4_idle_busy", busy, 0);

    // GAP=0 build: back-to-back frames 8'h81 then 8'h7E
    g0_valid = 1'b1;
    g0_data  = 8'h81;
    settle();
    check("t5_ready0_a", g_ready0, 1);
    tick();
    g0_data = 8'h7E;
    w = 8'h81;
    for (int k = 0; k < 8; k++) begin
      settle();
      check($sformatf("t5_a_sout_bit%0d", k), g_sout, w[7-k]);
      check($sformatf("t5_a_sout_en_bit%0d", k), g_sout_en, 1);
      check($sformatf("t5_a_done_bit%0d", k), g_done, (k == 7));
      check($sformatf("t5_a_ready0_bit%0d", k), g_ready0, 0);
      tick();
    end
    settle();
    check("t5_idle_sout_en", g_sout_en, 0);
    check("t5_idle_busy", g_busy, 0);
    check("t5_ready0_b", g_ready0, 1);
    tick();
    g0_valid = 1'b0;
    w = 8'h7E;
    for (int k = 0; k < 8; k++) begin
      settle();
      check($sformatf("t5_b_sout_bit%0d", k), g_sout, w[7-k]);
      check($sformatf("t5_b_done_bit%0d", k), g_done, (k == 7));
      tick();
    end
    settle();
    check("t5_end_busy", g_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/siso_frame_arbiter.md
Name: siso_frame_arbiter

Overview:
- Controller that shares one serial-in/serial-out shift channel between two parallel requesters.
- Each frame: round-robin grant, parallel word load, MSB-first shift-out of WIDTH bits with a framing enable, then a configurable inter-frame gap.
- Sits in front of the serial link and drives its `sin` data line plus a qualifying enable.

Parameters:
- WIDTH, 8, bits per frame (≥2)
- GAP, 1, idle cycles forced between frames (0..15)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a word
- req0_data  input  WIDTH  requester 0 word
- req0_ready  output  1  requester 0 word accepted this cycle
- req1_valid  input  1  requester 1 has a word
- req1_data  input  WIDTH  requester 1 word
- req1_ready  output  1  requester 1 word accepted this cycle
- sout  output  1  serial data to channel, MSB first
- sout_en  output  1  high while sout carries a frame bit
- busy  output  1  high in SHIFT or GAP
- grant_id  output  1  requester owning the current or most recent frame
- done  output  1  one-cycle pulse on the last bit of a frame

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high.
- Reset values: sout=0, sout_en=0, busy=0, done=0, req0_ready=0, req1_ready=0, grant_id=0, state=IDLE, bit counter=0, round-robin pointer favours req0.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - readyX is combinational and asserted only in IDLE, only for the granted requester.
  - At most one ready is high per cycle.
  - Arbitration:
    - Only one valid high: grant that requester.
    - Both valid: grant the requester not granted last.
  - A transfer occurs on validX & readyX in cycle N. Then:
    - shift register <= reqX_data
    - grant_id <= X
    - counter <= 0
    - pointer updated
    - state <= SHIFT
- SHIFT:
  - sout = shift register MSB.
  - sout_en = 1.
  - busy = 1.
  - Register shifts left by one each cycle; the counter increments.
  - Bit k (MSB = k=0) appears in cycle N+1+k.
  - In the cycle with counter == WIDTH-1, done = 1.
  - Next state is GAP, or IDLE if GAP == 0.
- GAP:
  - sout = 0, sout_en = 0, busy = 1.
  - The gap counter runs for exactly GAP cycles, then the state returns to IDLE.
- Latency:
  - First bit 1 cycle after the handshake; last bit WIDTH cycles after it.
  - Earliest next handshake: cycle N+WIDTH+1+GAP.
- Valid without grant:
  - The word is not consumed.
  - The requester must hold valid and data stable until ready.
  - Dropping valid before ready is legal and simply withdraws the request.
- Outside SHIFT, sout = 0 and sout_en = 0.
- Data inputs are ignored except in the handshake cycle. Changes to a requester's data during SHIFT do not affect the frame.
- Reset mid-frame, in any state:
  - The next cycle is IDLE with all outputs at reset values.
  - done is not asserted for the aborted frame.
  - The pointer returns to favour req0.
- rst and valid high in the same cycle: rst wins, no handshake.
- The bit counter never wraps past WIDTH-1. The gap counter is sized for GAP max 15.

Test Plan:
- Reset then single frame: rst 2 cycles, req0_valid=1, req0_data=8'hB4 → req0_ready high one cycle (N). sout over N+1..N+8 = 1,0,1,1,0,1,0,0. sout_en high exactly those 8 cycles. done only at N+8. grant_id=0.
- Contention round-robin: both valid continuously, data0=8'hFF, data1=8'h00 → grants alternate 0,1,0,1. Frames alternate all-ones/all-zeros. With GAP=1, frame starts are 10 cycles apart.
- Held request: req1_valid high during a req0 frame → req1_ready stays 0 until IDLE, then asserts. req1 frame shifts 8'h5A as 0,1,0,1,1,0,1,0.
- Reset mid-frame: assert rst after 3 bits of 8'hC3 → next cycle sout_en=0, busy=0, done never pulses. A following req1-only request is granted with grant_id=1.
- GAP=0 build: back-to-back req0 frames 8'h81, 8'h7E → the second handshake occurs the cycle after done. Serial stream is 1000000101111110 with 1 idle cycle (sout_en=0) between frames.
- Data change during shift: alter req0_data mid-frame → shifted bits match the word captured at the handshake.
